// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decodes I/S/B/U/J immediates from inst[31:7] into an XLEN-wide
// value behind a valid/ready handshake with an output register plus one skid entry.
module imm_gen_pipe #(
    parameter int XLEN  = 32,   // 32 or 64
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [24:0]      din,
    input  logic             sext,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic             imm_err,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [2:0] {
        FMT_I = 3'b000,
        FMT_S = 3'b010,
        FMT_B = 3'b110,
        FMT_U = 3'b011,
        FMT_J = 3'b111
    } fmt_e;

    logic            in_ready_q,  in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_imm_q,   out_imm_d;
    logic            out_err_q,   out_err_d;
    logic            skid_valid_q, skid_valid_d;
    logic [XLEN-1:0] skid_imm_q,  skid_imm_d;
    logic            skid_err_q,  skid_err_d;
    logic [CNT_W-1:0] err_cnt_q,  err_cnt_d;

    logic [31:0]     raw32;
    logic            sign_bit;
    logic            illegal;
    logic [XLEN-1:0] imm_new;
    logic            accept;

    // Every field is first assembled as a 32-bit value (already sign-filled to 32 bits when
    // sext=1), then widened to XLEN; this keeps U-type sext-neutral at XLEN=32.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        raw32    = '0;
        illegal  = 1'b0;
        sign_bit = sext & din[24];
        case (op)
            FMT_I:   raw32 = {{20{sign_bit}}, din[24:13]};
            FMT_S:   raw32 = {{20{sign_bit}}, din[24:18], din[4:0]};
            FMT_B:   raw32 = {{19{sign_bit}}, din[24], din[0], din[23:18], din[4:1], 1'b0};
            FMT_U:   raw32 = {din[24:5], 12'b0};
            FMT_J:   raw32 = {{11{sign_bit}}, din[24], din[12:5], din[13], din[23:14], 1'b0};
            default: illegal = 1'b1;
        endcase
        if (sext) begin
            imm_new = XLEN'($signed(raw32));
        end else begin
            imm_new = XLEN'(raw32);
        end
    end

    assign accept = in_valid & in_ready_q & ~flush;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_imm_d    = out_imm_q;
        out_err_d    = out_err_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_err_d   = skid_err_q;
        err_cnt_d    = err_cnt_q;

        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_valid_q && !out_ready) begin
            // Output stalled: a new beat can only land in the skid entry (in_ready guarantees it is free).
            if (accept) begin
                skid_valid_d = 1'b1;
                skid_imm_d   = imm_new;
                skid_err_d   = illegal;
            end
        end else if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_imm_d    = skid_imm_q;
            out_err_d    = skid_err_q;
            skid_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_imm_d   = imm_new;
            out_err_d   = illegal;
        end else begin
            out_valid_d = 1'b0;
        end

        if (accept && illegal && !(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end

        in_ready_d = ~skid_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_imm_q    <= '0;
            out_err_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_err_q   <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so all flops update together.
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_imm_q    <= out_imm_d;
            out_err_q    <= out_err_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_err_q   <= skid_err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign imm       = out_imm_q;
    assign imm_err   = out_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: one XLEN=32/CNT_W=2 instance and one XLEN=64/CNT_W=16 instance
// share the same stimulus; expected values are hand-computed constants.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [2:0]  op;
    logic [24:0] din;
    logic        sext;
    logic        out_ready;

    logic        in_ready32, out_valid32, imm_err32;
    logic [31:0] imm32;
    logic [1:0]  err_cnt32;
    logic        in_ready64, out_valid64, imm_err64;
    logic [63:0] imm64;
    logic [15:0] err_cnt64;

    int total = 0;
    int bad   = 0;
    int exp_cnt64 = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .CNT_W(2)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
        .op(op), .din(din), .sext(sext), .out_valid(out_valid32), .out_ready(out_ready),
        .imm(imm32), .imm_err(imm_err32), .err_cnt(err_cnt32)
    );

    imm_gen_pipe #(.XLEN(64), .CNT_W(16)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .op(op), .din(din), .sext(sext), .out_valid(out_valid64), .out_ready(out_ready),
        .imm(imm64), .imm_err(imm_err64), .err_cnt(err_cnt64)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic put(input logic [2:0] o, input logic [24:0] d, input logic s);
        op       = o;
        din      = d;
        sext     = s;
        in_valid = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One beat with out_ready high: it must appear on the output right after its accepting edge.
    task automatic one(input string tag, input logic [2:0] o, input logic [24:0] d, input logic s,
                       input logic [31:0] e32, input logic [63:0] e64, input logic e);
        put(o, d, s);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        if (e) exp_cnt64++;
        check({tag, "_v32"},   {63'd0, out_valid32}, 64'd1);
        check({tag, "_v64"},   {63'd0, out_valid64}, 64'd1);
        check({tag, "_imm32"}, {32'd0, imm32}, {32'd0, e32});
        check({tag, "_imm64"}, imm64, e64);
        check({tag, "_err"},   {63'd0, imm_err32}, {63'd0, e});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] ill_ops [5];
        ill_ops = '{3'b001, 3'b100, 3'b101, 3'b001, 3'b001};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; op = '0; din = '0; sext = 1'b0;
        out_ready = 1'b0;
        #12;
        check("rst_in_ready",  {63'd0, in_ready32},  64'd0);
        check("rst_out_valid", {63'd0, out_valid32}, 64'd0);
        check("rst_imm",       imm64,                64'd0);
        check("rst_imm_err",   {63'd0, imm_err32},   64'd0);
        check("rst_err_cnt",   {48'd0, err_cnt64},   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("rel_in_ready",  {63'd0, in_ready32},  64'd1);
        check("rel_out_valid", {63'd0, out_valid32}, 64'd0);

        // Format decode, back-to-back at one beat per cycle.
        one("i_s1",   3'b000, 25'h1FFE000, 1'b1, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        one("i_s0",   3'b000, 25'h1FFE000, 1'b0, 32'h0000_0FFF, 64'h0000_0000_0000_0FFF, 1'b0);
        one("b_beq",  3'b110, 25'h1FC001D, 1'b1, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        one("u_s1",   3'b011, 25'h1000000, 1'b1, 32'h8000_0000, 64'hFFFF_FFFF_8000_0000, 1'b0);
        one("u_s0",   3'b011, 25'h1000000, 1'b0, 32'h8000_0000, 64'h0000_0000_8000_0000, 1'b0);
        one("s_neg",  3'b010, 25'h1000000, 1'b1, 32'hFFFF_F800, 64'hFFFF_FFFF_FFFF_F800, 1'b0);
        one("s_pos",  3'b010, 25'h0000005, 1'b1, 32'h0000_0005, 64'h0000_0000_0000_0005, 1'b0);
        one("b_mid",  3'b110, 25'h000001F, 1'b0, 32'h0000_081E, 64'h0000_0000_0000_081E, 1'b0);
        one("j_mid",  3'b111, 25'h0003FE0, 1'b1, 32'h000F_F800, 64'h0000_0000_000F_F800, 1'b0);
        one("j_s1",   3'b111, 25'h1000000, 1'b1, 32'hFFF0_0000, 64'hFFFF_FFFF_FFF0_0000, 1'b0);
        one("j_s0",   3'b111, 25'h1000000, 1'b0, 32'h0010_0000, 64'h0000_0000_0010_0000, 1'b0);

        // Illegal codes: imm forced to zero; the 2-bit counter saturates at 3.
        for (int i = 0; i < 5; i++) begin
            one($sformatf("ill%0d", i), ill_ops[i], 25'h1FFFFFF, 1'b1, 32'd0, 64'd0, 1'b1);
            check($sformatf("ill%0d_cnt32", i), {62'd0, err_cnt32}, (i < 3) ? 64'(i + 1) : 64'd3);
            check($sformatf("ill%0d_cnt64", i), {48'd0, err_cnt64}, 64'(exp_cnt64));
        end
        step();
        check("drain_valid", {63'd0, out_valid32}, 64'd0);

        // Backpressure: A in output, B in skid, C held off until space frees up.
        out_ready = 1'b0;
        put(3'b000, 25'h0002000, 1'b0);
        step();
        check("bp_a_valid", {63'd0, out_valid32}, 64'd1);
        check("bp_a_rdy",   {63'd0, in_ready32},  64'd1);
        put(3'b000, 25'h0004000, 1'b0);
        step();
        check("bp_b_rdy",   {63'd0, in_ready32},  64'd0);
        check("bp_b_imm",   {32'd0, imm32},       64'd1);
        put(3'b000, 25'h0006000, 1'b0);
        step();
        check("bp_c_rdy",   {63'd0, in_ready32},  64'd0);
        check("bp_hold1",   {32'd0, imm32},       64'd1);
        step();
        check("bp_hold2",   {32'd0, imm32},       64'd1);
        out_ready = 1'b1;
        step();
        check("bp_out_b",   {32'd0, imm32},       64'd2);
        check("bp_rdy_back", {63'd0, in_ready32}, 64'd1);
        step();
        in_valid = 1'b0;
        check("bp_out_c",   {32'd0, imm32},       64'd3);
        check("bp_c_valid", {63'd0, out_valid32}, 64'd1);
        step();
        check("bp_empty",   {63'd0, out_valid32}, 64'd0);

        // Flush with both entries full; the illegal beat in the skid was counted on acceptance.
        out_ready = 1'b0;
        put(3'b000, 25'h0002000, 1'b0);
        step();
        put(3'b100, 25'h0000000, 1'b0);
        step();
        exp_cnt64++;
        in_valid = 1'b0;
        check("fl_full_rdy", {63'd0, in_ready32}, 64'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl_valid",  {63'd0, out_valid32}, 64'd0);
        check("fl_rdy",    {63'd0, in_ready32},  64'd1);
        check("fl_cnt64",  {48'd0, err_cnt64},   64'(exp_cnt64));

        // Flush overrides a same-cycle accept: beat dropped, not counted.
        out_ready = 1'b1;
        put(3'b101, 25'h0000000, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flacc_valid", {63'd0, out_valid32}, 64'd0);
        check("flacc_cnt64", {48'd0, err_cnt64},   64'(exp_cnt64));

        // Async reset in the middle of a stall.
        out_ready = 1'b0;
        put(3'b000, 25'h0002000, 1'b0);
        step();
        put(3'b000, 25'h0004000, 1'b0);
        step();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", {63'd0, out_valid32}, 64'd0);
        check("ar_cnt64", {48'd0, err_cnt64},   64'd0);
        check("ar_rdy",   {63'd0, in_ready32},  64'd0);
        check("ar_imm",   imm64,                64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("ar_rel_rdy", {63'd0, in_ready32}, 64'd1);
        one("post_rst", 3'b111, 25'h0003FE0, 1'b1, 32'h000F_F800, 64'h0000_0000_000F_F800, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
